// File: rtl/fare_pkg.sv
// Shared definitions for the fare table builder: bus widths, line offsets,
// the sequencer state type and the hop-distance helper.
package fare_pkg;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 12;
    localparam int FARE_W = 4;

    // Global station index of the first station of each line.
    localparam int LINE_OFS [4] = '{0, 27, 53, 82};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } fare_state_e;

    function automatic logic [ADDR_W-1:0] abs_diff(input logic [ADDR_W-1:0] a,
                                                   input logic [ADDR_W-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/fare_calc.sv
// Combinational fare tier lookup from start/end station indices.
module fare_calc
    import fare_pkg::*;
#(
    parameter int T1 = 5,
    parameter int T2 = 10,
    parameter int T3 = 15,
    parameter int F1 = 2,
    parameter int F2 = 3,
    parameter int F3 = 4,
    parameter int F4 = 5
) (
    input  logic [ADDR_W-1:0] s,
    input  logic [ADDR_W-1:0] e,
    output logic [FARE_W-1:0] fare
);

    logic [ADDR_W-1:0] dist_s;

    assign dist_s = abs_diff(s, e);

    // Tier selection; a trip to the same station is free.
    always_comb begin
        fare = {FARE_W{1'b0}};
        if (dist_s == {ADDR_W{1'b0}}) begin
            fare = {FARE_W{1'b0}};
        end else if (dist_s <= ADDR_W'(T1)) begin
            fare = FARE_W'(F1);
        end else if (dist_s <= ADDR_W'(T2)) begin
            fare = FARE_W'(F2);
        end else if (dist_s <= ADDR_W'(T3)) begin
            fare = FARE_W'(F3);
        end else begin
            fare = FARE_W'(F4);
        end
    end

endmodule

// File: rtl/fare_table_writer.sv
// Fills the STATIONS x STATIONS fare RAM, one write per cycle, and optionally
// reads it back for verification when FARE_TABLE_READBACK_EN is defined.
module fare_table_writer
    import fare_pkg::*;
#(
    parameter int STATIONS   = 100,
    parameter int ROW_STRIDE = 100,
    parameter int T1         = 5,
    parameter int T2         = 10,
    parameter int T3         = 15,
    parameter int F1         = 2,
    parameter int F2         = 3,
    parameter int F3         = 4,
    parameter int F4         = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(STATIONS - 1);
    localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(ROW_STRIDE);

    fare_state_e       state_r, state_nxt_s;
    logic [ADDR_W-1:0] s_r, e_r, row_r;
    logic [ADDR_W-1:0] s_nxt_s, e_nxt_s, row_nxt_s;
    logic              rd_vld_r, rd_vld_nxt_s;
    logic              busy_r, done_r, err_r, we_r;
    logic              busy_nxt_s, done_nxt_s, err_nxt_s, we_nxt_s;
    logic [ADDR_W-1:0] addr_r, addr_nxt_s;
    logic [DATA_W-1:0] din_r, din_nxt_s;
    logic [FARE_W-1:0] fare_s;
    logic              at_last_s;
    logic              mismatch_s;
    logic              unused_dout_s;

    // Fare for the cell that will be addressed in the coming cycle.
    fare_calc #(
        .T1(T1), .T2(T2), .T3(T3),
        .F1(F1), .F2(F2), .F3(F3), .F4(F4)
    ) u_fare_calc (
        .s    (s_nxt_s),
        .e    (e_nxt_s),
        .fare (fare_s)
    );

`ifdef FARE_TABLE_READBACK_EN
    logic [FARE_W-1:0] exp_r, cmp_exp_r;
    logic              cmp_vld_r;

    // Expected-fare pipeline aligned with the RAM's one-cycle read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_r     <= {FARE_W{1'b0}};
            cmp_exp_r <= {FARE_W{1'b0}};
            cmp_vld_r <= 1'b0;
        end else begin
            exp_r     <= fare_s;
            cmp_exp_r <= exp_r;
            cmp_vld_r <= rd_vld_r;
        end
    end

    assign mismatch_s    = cmp_vld_r && (ram_dout[FARE_W-1:0] != cmp_exp_r);
    assign unused_dout_s = ^ram_dout[DATA_W-1:FARE_W];
`else
    assign mismatch_s    = 1'b0;
    assign unused_dout_s = ^ram_dout;
`endif

    assign at_last_s = (s_r == LAST_IDX) && (e_r == LAST_IDX);

    // Sequencer next state, counter stepping and next RAM command.
    always_comb begin
        state_nxt_s  = state_r;
        s_nxt_s      = s_r;
        e_nxt_s      = e_r;
        row_nxt_s    = row_r;
        we_nxt_s     = 1'b0;
        rd_vld_nxt_s = 1'b0;
        done_nxt_s   = done_r;
        err_nxt_s    = err_r;

        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = FILL;
                    s_nxt_s     = {ADDR_W{1'b0}};
                    e_nxt_s     = {ADDR_W{1'b0}};
                    row_nxt_s   = {ADDR_W{1'b0}};
                    we_nxt_s    = 1'b1;
                    done_nxt_s  = 1'b0;
                    err_nxt_s   = 1'b0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FILL: begin
                if (at_last_s) begin
`ifdef FARE_TABLE_READBACK_EN
                    state_nxt_s  = CHECK;
                    s_nxt_s      = {ADDR_W{1'b0}};
                    e_nxt_s      = {ADDR_W{1'b0}};
                    row_nxt_s    = {ADDR_W{1'b0}};
                    rd_vld_nxt_s = 1'b1;
`else
                    state_nxt_s  = DONE;
`endif
                end else if (e_r == LAST_IDX) begin
                    s_nxt_s   = s_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    e_nxt_s   = {ADDR_W{1'b0}};
                    row_nxt_s = row_r + STRIDE;
                    we_nxt_s  = 1'b1;
                end else begin
                    e_nxt_s   = e_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    we_nxt_s  = 1'b1;
                end
            end
            CHECK: begin
                // Once the last read is issued, one more cycle drains its compare.
                if (!rd_vld_r) begin
                    state_nxt_s = DONE;
                end else if (at_last_s) begin
                    rd_vld_nxt_s = 1'b0;
                end else if (e_r == LAST_IDX) begin
                    s_nxt_s      = s_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    e_nxt_s      = {ADDR_W{1'b0}};
                    row_nxt_s    = row_r + STRIDE;
                    rd_vld_nxt_s = 1'b1;
                end else begin
                    e_nxt_s      = e_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    rd_vld_nxt_s = 1'b1;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
                done_nxt_s  = 1'b1;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase

        err_nxt_s  = err_nxt_s | mismatch_s;
        busy_nxt_s = (state_nxt_s == FILL) || (state_nxt_s == CHECK);
        addr_nxt_s = row_nxt_s + e_nxt_s;
        din_nxt_s  = we_nxt_s ? {{(DATA_W-FARE_W){1'b0}}, fare_s} : {DATA_W{1'b0}};
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            s_r      <= {ADDR_W{1'b0}};
            e_r      <= {ADDR_W{1'b0}};
            row_r    <= {ADDR_W{1'b0}};
            rd_vld_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            we_r     <= 1'b0;
            addr_r   <= {ADDR_W{1'b0}};
            din_r    <= {DATA_W{1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            s_r      <= s_nxt_s;
            e_r      <= e_nxt_s;
            row_r    <= row_nxt_s;
            rd_vld_r <= rd_vld_nxt_s;
            busy_r   <= busy_nxt_s;
            done_r   <= done_nxt_s;
            err_r    <= err_nxt_s;
            we_r     <= we_nxt_s;
            addr_r   <= addr_nxt_s;
            din_r    <= din_nxt_s;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign err      = err_r;
    assign ram_we   = we_r;
    assign ram_addr = addr_r;
    assign ram_din  = din_r;

endmodule

// File: doc/fare_table_writer.md
FARE_TABLE_WRITER -- requirements
Module: fare_table_writer

Interface
REQ-001 SHALL have parameter STATIONS, default 100, number of global station indices per axis (0..STATIONS-1).
REQ-002 SHALL have parameter ROW_STRIDE, default 100, address stride per start-station row.
REQ-003 SHALL have parameters T1/T2/T3, defaults 5/10/15, hop-distance tier limits.
REQ-004 SHALL have parameters F1/F2/F3/F4, defaults 2/3/4/5, 4-bit fare per tier.
REQ-005 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  in  1  single-cycle request to (re)build the fare table.
REQ-008 SHALL have port busy  out  1  high while filling or checking.
REQ-009 SHALL have port done  out  1  table complete; held high until the next accepted start.
REQ-010 SHALL have port err  out  1  sticky readback mismatch flag.
REQ-011 SHALL have port ram_we  out  1  write enable to the fare RAM port A.
REQ-012 SHALL have port ram_addr  out  19  RAM port A address.
REQ-013 SHALL have port ram_din  out  12  write data; fare in [3:0], [11:4] zero.
REQ-014 SHALL have port ram_dout  in  12  RAM port A read data, 1-cycle read latency.

Function
REQ-015 SHALL implement FSM states IDLE, FILL, CHECK, DONE.
REQ-016 SHALL, in IDLE, accept start and move to FILL next cycle; start in any other state is ignored.
REQ-017 SHALL, on accepted start, clear done and err and zero counters s (outer) and e (inner).
REQ-018 SHALL, in FILL, issue one write per cycle: ram_we=1, ram_addr=s*ROW_STRIDE+e, e incrementing, wrapping to 0 with s+1.
REQ-019 SHALL compute fare from d=|s-e|: d=0 -> 0; d<=T1 -> F1; d<=T2 -> F2; d<=T3 -> F3; else F4.
REQ-020 SHALL drive all RAM outputs from registers; first write (addr 0) appears the first FILL cycle, one cycle after start sampled.
REQ-021 SHALL leave FILL after the write with s=e=STATIONS-1 (addr 9999 at defaults); exactly STATIONS*STATIONS writes, no gaps.
REQ-022 SHALL hold ram_we=0 in IDLE, CHECK and DONE.
REQ-023 SHALL, in DONE (one cycle), set done=1, busy=0 next cycle, return to IDLE.
REQ-024 SHALL assert busy in FILL and CHECK only.
REQ-025 SHALL size internal address arithmetic at 19 bits with no truncation for parameter values up to STATIONS*ROW_STRIDE <= 2^19.

Reset
REQ-026 SHALL, on rst_n low, immediately force state IDLE, busy=0, done=0, err=0, ram_we=0, ram_addr=0, ram_din=0.
REQ-027 SHALL, on reset mid-FILL, abandon the fill; RAM content is then undefined and done stays 0 until a full rebuild.

Configuration
REQ-028 SHALL, with FARE_TABLE_READBACK_EN defined, enter CHECK after FILL: re-issue addresses 0..last with ram_we=0, compare ram_dout[3:0] one cycle later with the delayed expected fare, set err on any mismatch, enter DONE after the last compare.
REQ-029 SHALL, without FARE_TABLE_READBACK_EN, go FILL -> DONE directly, tie err to 0 and ignore ram_dout.

Structure
REQ-030 SHALL take ADDR_W=19, DATA_W=12, FARE_W=4, line offsets (0,27,53,82) and the state enum from shared package fare_pkg.
REQ-031 SHALL place tier logic in sub-module fare_calc (pure combinational, s/e in, fare out), reused by FILL and CHECK.

Verification
REQ-032 SHALL check: rst_n low with start toggling -> all outputs 0, no write.
REQ-033 SHALL check: start pulse in IDLE -> next cycle ram_we=1, addr 0, din 0; busy=1.
REQ-034 SHALL check: write at s=3,e=10 -> addr 310, din 0x003; s=0,e=20 -> addr 20, din 0x005.
REQ-035 SHALL check: full run -> 10000 writes, last addr 9999 din 0, done=1 after DONE; start pulses during FILL ignored.
REQ-036 SHALL check (macro on): RAM model corrupts addr 310 to 0x007 -> err=1 at DONE; clean model -> err=0.
REQ-037 SHALL check: rst_n low at write addr 5000 -> ram_we=0 same cycle, done=0, fresh start restarts at addr 0.
